// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM encoding and word/checksum constants for the instruction memory loader
package imem_loader_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int CHECKSUM_W     = 32;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles four big-endian bytes into a 32-bit word with a one-cycle word_valid strobe
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_en,
    output logic        last,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  idx;
    logic [23:0] sh;

    assign last = byte_en && idx == 2'(BYTES_PER_WORD - 1);

    // shift bytes in; the completed word is latched and held until the next word completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            sh         <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else if (clear) begin
            idx        <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= last;
            if (byte_en) begin
                idx <= idx + 2'd1;
                sh  <= {sh[15:0], byte_in};
                if (last) word <= {sh, byte_in};
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams bytes into instruction memory, then releases the core; IMEM_LOADER_CHECKSUM_EN adds a trailing checksum word
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] max_words = {1'b1, {ADDR_W{1'b0}}};

    state_t          state, state_nxt;
    logic [ADDR_W:0] count, wcnt;
    logic            last_pend, last_nxt;
    logic            xfer, last_byte, word_valid;
    logic            can_start, start_ok, start_bad, final_byte;
    logic            chk_end, chk_bad;
    logic [31:0]     word;

    assign xfer       = byte_valid && byte_ready;
    assign can_start  = start && (state == IDLE || state == DONE);
    assign start_ok   = can_start && word_count != '0 && word_count <= max_words;
    assign start_bad  = can_start && !start_ok;
    assign final_byte = state == LOAD && last_byte && wcnt == count - (ADDR_W+1)'(1);
    assign imem_we    = word_valid && state == LOAD;
    assign imem_wdata = word;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .byte_in    (byte_in),
        .byte_en    (xfer),
        .last       (last_byte),
        .word       (word),
        .word_valid (word_valid)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t load_exit = CHECK;
    logic [CHECKSUM_W-1:0] sum;
    assign chk_end = state == CHECK && word_valid;
    assign chk_bad = chk_end && word != sum;
    // running sum of every word actually written to memory
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sum <= '0;
        else if (start_ok) sum <= '0;
        else if (imem_we) sum <= sum + word;
    end
`else
    localparam state_t load_exit = DONE;
    assign chk_end = 1'b0;
    assign chk_bad = 1'b0;
`endif

    // next state; the last word's write cycle finishes in LOAD with byte_ready low
    always_comb begin
        state_nxt = state;
        if (start_bad) state_nxt = IDLE;
        else if (start_ok) state_nxt = LOAD;
        else if (state == LOAD && imem_we && last_pend) state_nxt = load_exit;
        else if (chk_end) state_nxt = chk_bad ? IDLE : DONE;
        last_nxt = !start_ok && (final_byte || (last_pend && state_nxt == LOAD));
    end

    // state, registered status outputs, word counter and write address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            wcnt       <= '0;
            last_pend  <= 1'b0;
            imem_addr  <= '0;
            err        <= 1'b0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            core_reset <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_pend  <= last_nxt;
            err        <= start_bad || chk_bad;
            byte_ready <= state_nxt == CHECK || (state_nxt == LOAD && !last_nxt);
            busy       <= state_nxt == LOAD || state_nxt == CHECK;
            done       <= state_nxt == DONE;
            core_reset <= state_nxt != DONE;
            if (start_ok) begin
                count     <= word_count;
                wcnt      <= '0;
                imem_addr <= '0;
            end else begin
                if (state == LOAD && last_byte) wcnt <= wcnt + (ADDR_W+1)'(1);
                if (imem_we && !last_pend) imem_addr <= imem_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for imem_loader (ADDR_W=3)
module tb_imem_loader;

    localparam int AW = 3;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, byte_valid = 1'b0;
    logic [AW:0]   word_count = '0;
    logic [7:0]    byte_in = '0;
    logic          byte_ready, imem_we, core_reset, busy, done, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    int tests = 0, fails = 0, nwrites = 0;
    logic [AW+31:0] exp_q[$];
    logic [31:0]    wbuf[8];

    imem_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every write must match the oldest expected (addr, data)
    always @(negedge clk) begin : mon
        logic [AW+31:0] e;
        if (imem_we) begin
            nwrites++;
            if (exp_q.size() == 0) check("unexpected_we", 64'(imem_we), 64'(0));
            else begin
                e = exp_q.pop_front();
                check("we_addr", 64'(imem_addr), 64'(e[AW+31:32]));
                check("we_data", 64'(imem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic do_start(input int wc);
        @(negedge clk);
        start = 1'b1;
        word_count = (AW+1)'(wc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        byte_in = b;
        byte_valid = 1'b1;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("byte_timeout", 64'(t), 64'(0));
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int b = 3; b >= 0; b--) begin
            send_byte(w[b*8 +: 8]);
            if (gap) begin
                @(negedge clk);
                byte_valid = 1'b0;
            end
        end
    endtask

    task automatic load(input int n, input bit gap, input bit bad_sum);
        logic [31:0] sum = '0;
        do_start(n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({AW'(i), wbuf[i]});
            sum += wbuf[i];
            send_word(wbuf[i], gap);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(bad_sum ? sum + 32'd1 : sum, gap);
`else
        if (bad_sum) $display("[TB] checksum disabled, bad_sum ignored");
`endif
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        check({tag, "_done"}, 64'(done), 64'(1));
        check({tag, "_core_reset"}, 64'(core_reset), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_ready"}, 64'(byte_ready), 64'(0));
        check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_bad_start(input int wc, input string tag);
        int w0 = nwrites;
        do_start(wc);
        check({tag, "_err"}, 64'(err), 64'(1));
        check({tag, "_core_reset"}, 64'(core_reset), 64'(1));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        @(negedge clk);
        check({tag, "_err_pulse"}, 64'(err), 64'(0));
        check({tag, "_no_we"}, 64'(nwrites), 64'(w0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(byte_ready), 64'(0));
        check({tag, "_we"}, 64'(imem_we), 64'(0));
        check({tag, "_addr"}, 64'(imem_addr), 64'(0));
        check({tag, "_wdata"}, 64'(imem_wdata), 64'(0));
        check({tag, "_core_reset"}, 64'(core_reset), 64'(1));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;

        wbuf[0] = 32'h20080005;
        wbuf[1] = 32'h20090003;
        load(2, 1'b0, 1'b0);
        wait_done("two_words");

        check_bad_start(0, "wc_zero");
        check_bad_start(9, "wc_over");

        wbuf[0] = 32'hDEADBEEF;
        wbuf[1] = 32'h01234567;
        wbuf[2] = 32'h89ABCDEF;
        load(3, 1'b0, 1'b0);
        wait_done("gapless3");
        load(3, 1'b1, 1'b0);
        wait_done("gap3");

        for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000_0000 + 32'(i * 32'h0101_0101);
        load(8, 1'b0, 1'b0);
        wait_done("full8");
        check("full8_last_addr", 64'(imem_addr), 64'(7));
        check("full8_writes", 64'(nwrites), 64'(2 + 3 + 3 + 8));

        wbuf[0] = 32'hA1A2A3A4;
        wbuf[1] = 32'hB1B2B3B4;
        wbuf[2] = 32'hC1C2C3C4;
        do_start(3);
        exp_q.push_back({AW'(0), wbuf[0]});
        send_word(wbuf[0], 1'b0);
        send_byte(8'hB1);
        send_byte(8'hB2);
        @(negedge clk);
        byte_valid = 1'b0;
        reset = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        check("midrst_no_we", 64'(imem_we), 64'(0));
        check("midrst_sb_empty", 64'(exp_q.size()), 64'(0));
        reset = 1'b1;
        load(3, 1'b0, 1'b0);
        wait_done("reload");

        wbuf[0] = 32'h11112222;
        wbuf[1] = 32'h33334444;
        do_start(2);
        @(negedge clk);
        start = 1'b1;
        word_count = (AW+1)'(1);
        @(negedge clk);
        start = 1'b0;
        check("ign_start_busy", 64'(busy), 64'(1));
        check("ign_start_err", 64'(err), 64'(0));
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({AW'(i), wbuf[i]});
            send_word(wbuf[i], 1'b0);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(wbuf[0] + wbuf[1], 1'b0);
`endif
        @(negedge clk);
        byte_valid = 1'b0;
        wait_done("ign_start");

`ifdef IMEM_LOADER_CHECKSUM_EN
        wbuf[0] = 32'h00000001;
        wbuf[1] = 32'h00000002;
        load(2, 1'b0, 1'b0);
        wait_done("csum_ok");
        load(2, 1'b0, 1'b1);
        for (int i = 0; i < 20 && !err; i++) @(negedge clk);
        check("csum_bad_err", 64'(err), 64'(1));
        check("csum_bad_core_reset", 64'(core_reset), 64'(1));
        check("csum_bad_done", 64'(done), 64'(0));
        check("csum_bad_busy", 64'(busy), 64'(0));
        @(negedge clk);
        check("csum_bad_err_pulse", 64'(err), 64'(0));
`endif

        repeat (3) @(negedge clk);
        check("final_sb_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of the instruction memory (2^ADDR_W words).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle load request.
REQ-005 SHALL have port word_count  input  ADDR_W+1  number of words to load, sampled on accepted start.
REQ-006 SHALL have ports byte_in  input  8  stream byte; byte_valid  input  1  byte present; byte_ready  output  1  loader can take a byte.
REQ-007 SHALL have ports imem_we  output  1; imem_addr  output  ADDR_W; imem_wdata  output  32  word-write port into instruction memory.
REQ-008 SHALL have ports core_reset  output  1  active-high reset to the processor core; busy  output  1; done  output  1; err  output  1.

Function
REQ-009 SHALL implement FSM states IDLE, LOAD, CHECK, DONE.
REQ-010 SHALL accept start only in IDLE or DONE; start in LOAD/CHECK SHALL be ignored.
REQ-011 SHALL, on accepted start with word_count == 0 or word_count > 2^ADDR_W, set err=1 for one cycle and go to IDLE.
REQ-012 SHALL, on a valid accepted start, clear the word counter and byte index, zero imem_addr, clear err, and enter LOAD next cycle.
REQ-013 SHALL drive byte_ready=1 only in LOAD and CHECK; a byte transfers when byte_valid && byte_ready on a rising edge.
REQ-014 SHALL pack bytes big-endian: first byte -> imem_wdata[31:24], fourth -> [7:0].
REQ-015 SHALL pulse imem_we for exactly one cycle in the cycle after the fourth byte of a word transfers, with the assembled word and current imem_addr stable during that cycle.
REQ-016 SHALL increment imem_addr by 1 in the cycle after each write; byte acceptance SHALL continue without stall during the write cycle.
REQ-017 SHALL, after writing word number word_count, leave LOAD (to CHECK if enabled, else DONE); no further byte_ready in LOAD.
REQ-018 SHALL, for word_count == 2^ADDR_W, write the final word at address 2^ADDR_W-1 and not wrap to 0 before leaving LOAD.
REQ-019 SHALL drive core_reset=1 in IDLE, LOAD, CHECK; 0 only in DONE.
REQ-020 SHALL drive busy=1 in LOAD and CHECK; done=1 in DONE.
REQ-021 SHALL hold a partial word indefinitely while byte_valid is low (no timeout).

Reset
REQ-022 SHALL, while reset=0, force state IDLE, core_reset=1, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, counters=0.
REQ-023 SHALL discard any partial word and not issue a pending write when reset asserts mid-load.

Configuration
REQ-024 SHALL support macro IMEM_LOADER_CHECKSUM_EN.
REQ-025 SHALL, with IMEM_LOADER_CHECKSUM_EN defined, keep a 32-bit running sum (mod 2^32) of written words, receive 4 further big-endian bytes in CHECK, and go to DONE on match or to IDLE with err=1 (one cycle) on mismatch.
REQ-026 SHALL, without IMEM_LOADER_CHECKSUM_EN, omit the CHECK state and sum logic and go LOAD -> DONE directly.

Structure
REQ-027 SHALL place the FSM state encoding, BYTES_PER_WORD=4, and checksum width constant in shared package imem_loader_pkg.
REQ-028 SHALL instantiate one sub-module byte_packer (4-byte to 32-bit word assembler with word_valid strobe), reused for data and checksum words.

Verification
REQ-029 SHALL test: start, word_count=2, bytes 20 08 00 05 20 09 00 03 -> imem_we at addr 0 data 0x20080005, then addr 1 data 0x20090003, done=1, core_reset=0.
REQ-030 SHALL test: word_count=0 and word_count=2^ADDR_W+1 -> err one-cycle pulse, state IDLE, core_reset=1, no imem_we.
REQ-031 SHALL test: byte_valid toggled every other cycle for 3 words -> identical writes to the gapless case, addresses 0,1,2.
REQ-032 SHALL test: reset low after 6 bytes of a 3-word load -> no write of word 1, all outputs at reset values; new start reloads from addr 0.
REQ-033 SHALL test with IMEM_LOADER_CHECKSUM_EN: words 0x00000001, 0x00000002, checksum 0x00000003 -> done=1; checksum 0x00000004 -> err pulse, IDLE, core_reset=1.
REQ-034 SHALL test: start asserted during LOAD -> ignored, load completes with original word_count.
